// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the seven-segment digit scanner.
// Defaults target a 100 MHz clock with a 1 kHz digit rate.
package fnd_pkg;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_NUM_BANKS    = 2;
  localparam int DEF_DATA_W       = 4;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_BLINK_FRAMES = 128;

  localparam int MAX_DIGITS = 8;
  typedef logic [MAX_DIGITS-1:0] com_t;

  localparam com_t COM_OFF = '1;

  // Active-low one-hot common pattern for a digit index; callers truncate to their width.
  function automatic com_t com_active(input int unsigned idx);
    return ~(com_t'(1) << idx);
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fnd_tick_div.sv
// Prescaler: one-cycle o_tick every REFRESH_DIV enabled clocks; holds while disabled.
module fnd_tick_div #(
  parameter int REFRESH_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign o_tick = i_enable && last;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (i_enable) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fnd_scan_mux.sv
// Time-multiplexed FND scanner: bank select at frame boundaries, per-digit blink,
// enable gating; all outputs registered with one cycle of latency.
module fnd_scan_mux
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int NUM_BANKS    = DEF_NUM_BANKS,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_enable,
  input  logic [NUM_BANKS*NUM_DIGITS*DATA_W-1:0] i_data,
  input  logic [sel_width(NUM_BANKS)-1:0]       i_bank_sel,
  input  logic [NUM_DIGITS-1:0]                 i_blink_mask,
  input  logic [NUM_DIGITS-1:0]                 i_dp_mask,
  output logic [DATA_W-1:0]                     o_digit,
  output logic [NUM_DIGITS-1:0]                 o_com,
  output logic                                  o_dp,
  output logic                                  o_frame_start
);

  localparam int SEL_W = sel_width(NUM_BANKS);
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIG_W-1:0]      digit_idx_q, digit_idx_d;
  logic [SEL_W-1:0]      bank_q, bank_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  start_pend_q, start_pend_d;
  logic [DATA_W-1:0]     digit_q, digit_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;
  logic                  tick;
  logic                  frame_wrap;

  fnd_tick_div #(.REFRESH_DIV(REFRESH_DIV)) u_tick_div (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  assign frame_wrap = tick && (digit_idx_q == DIG_W'(NUM_DIGITS - 1));

  always_comb begin
    digit_idx_d   = digit_idx_q;
    bank_d        = bank_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    start_pend_d  = start_pend_q;

    if (tick) digit_idx_d = frame_wrap ? '0 : digit_idx_q + 1'b1;

    // Frame boundary: latch a valid bank request and advance the blink timebase.
    if (frame_wrap) begin
      if (int'(i_bank_sel) < NUM_BANKS) bank_d = i_bank_sel;
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      start_pend_d = 1'b1;
    end else if (i_enable) begin
      start_pend_d = 1'b0;
    end
  end

  // Pending frame start is consumed by the first enabled cycle of digit 0, so a
  // disable/resume never repeats the pulse.
  always_comb begin
    digit_d = digit_q;
    com_d   = NUM_DIGITS'(COM_OFF);
    dp_d    = 1'b0;
    fs_d    = 1'b0;
    if (i_enable) begin
      digit_d = i_data[(int'(bank_q) * NUM_DIGITS + int'(digit_idx_q)) * DATA_W +: DATA_W];
      dp_d    = i_dp_mask[digit_idx_q];
      fs_d    = start_pend_q;
      if (!(blink_phase_q && i_blink_mask[digit_idx_q]))
        com_d = NUM_DIGITS'(com_active(int'(digit_idx_q)));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      digit_idx_q   <= '0;
      bank_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      start_pend_q  <= 1'b1;
      digit_q       <= '0;
      com_q         <= NUM_DIGITS'(COM_OFF);
      dp_q          <= 1'b0;
      fs_q          <= 1'b0;
    end else begin
      digit_idx_q   <= digit_idx_d;
      bank_q        <= bank_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      start_pend_q  <= start_pend_d;
      digit_q       <= digit_d;
      com_q         <= com_d;
      dp_q          <= dp_d;
      fs_q          <= fs_d;
    end
  end

  assign o_digit       = digit_q;
  assign o_com         = com_q;
  assign o_dp          = dp_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_mux.sv
// Self-checking bench for fnd_scan_mux: directed steps with random data, checked
// every cycle against an arithmetic model driven by a count of enabled cycles.
module tb_fnd_scan_mux;

  localparam int ND  = 4;
  localparam int NB  = 3;   // three banks so that select value 3 is out of range
  localparam int DW  = 4;
  localparam int DIV = 4;
  localparam int BF  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NB*ND*DW-1:0] data;
  logic [1:0]        sel;
  logic [ND-1:0]     blink, dp;
  logic [DW-1:0]     o_digit;
  logic [ND-1:0]     o_com;
  logic              o_dp, o_fs;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: enabled cycles since reset and the bank shown this frame.
  int          en_cnt = 0;
  int          m_bank = 0;
  logic [3:0]  e_com   = 4'hF;
  logic [3:0]  e_digit = 4'h0;
  logic        e_dp = 1'b0, e_fs = 1'b0;

  fnd_scan_mux #(
    .NUM_DIGITS(ND), .NUM_BANKS(NB), .DATA_W(DW),
    .REFRESH_DIV(DIV), .BLINK_FRAMES(BF)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_data        (data),
    .i_bank_sel    (sel),
    .i_blink_mask  (blink),
    .i_dp_mask     (dp),
    .o_digit       (o_digit),
    .o_com         (o_com),
    .o_dp          (o_dp),
    .o_frame_start (o_fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from pre-edge model state and current inputs, then compare.
  task automatic cycle();
    int d, fr;
    bit ph;
    logic [NB*ND*DW-1:0] sh;
    if (rst) begin
      e_com = 4'hF; e_digit = 4'h0; e_dp = 1'b0; e_fs = 1'b0;
      en_cnt = 0; m_bank = 0;
    end else if (en) begin
      d  = (en_cnt / DIV) % ND;
      fr = en_cnt / (DIV * ND);
      ph = ((fr / BF) % 2) == 1;
      e_com   = (ph && blink[d]) ? 4'hF : (4'hF ^ (4'h1 << d));
      sh      = data >> ((m_bank * ND + d) * DW);
      e_digit = sh[3:0];
      e_dp    = dp[d];
      e_fs    = (en_cnt % (DIV * ND)) == 0;
      en_cnt++;
      if ((en_cnt % (DIV * ND)) == 0 && int'(sel) < NB) m_bank = int'(sel);
    end else begin
      e_com = 4'hF; e_dp = 1'b0; e_fs = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("com", 32'(o_com), 32'(e_com));
    chk("digit", 32'(o_digit), 32'(e_digit));
    chk("dp", 32'(o_dp), 32'(e_dp));
    chk("frame_start", 32'(o_fs), 32'(e_fs));
    chk("com_one_hot0", 32'($countones(~o_com) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance (bounded) until the model is at the first tick of the given digit.
  task automatic run_to_digit(input int dig);
    int guard = 0;
    while (!(((en_cnt / DIV) % ND) == dig && (en_cnt % DIV) == 0) && guard < 64) begin
      cycle();
      guard++;
    end
    chk("reach_digit", 32'(guard < 64), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = 2'd0; blink = '0; dp = '0;
    data = {$urandom, $urandom};
    data[15:0]  = 16'h4321;
    data[31:16] = 16'h9876;

    // Reset state, then a plain scan of bank 0.
    run(3);
    rst = 1'b0; en = 1'b1;
    run(32);

    // Bank request mid-frame only takes effect at the next frame.
    run_to_digit(1);
    sel = 2'd1;
    run(40);

    // Blink digit 0 across six frames.
    sel = 2'd0;
    blink = 4'b0001;
    run(6 * DIV * ND);
    blink = '0;

    // Disable mid-slot for 10 cycles, then resume.
    run_to_digit(2);
    run(2);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(20);

    // Reset while on digit 2.
    run_to_digit(2);
    run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(20);

    // Decimal point on digit 2 with an out-of-range bank request.
    sel = 2'd2;
    run(DIV * ND + 4);
    dp  = 4'b0100;
    sel = 2'd3;
    run(3 * DIV * ND);

    // Randomized phase: data, masks, bank requests and enable gaps.
    for (int k = 0; k < 300; k++) begin
      if (k % 37 == 0) data = {$urandom, $urandom};
      if (k % 23 == 0) begin
        blink = 4'($urandom);
        dp    = 4'($urandom);
        sel   = 2'($urandom_range(0, 3));
      end
      en = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
